// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM.
// ADDI_EN adds the ADDIEX/ADDIWB states for addi.
package mc_ctrl_pkg;

    localparam int OPW = 6;
    localparam int STW = 4;

    typedef enum logic [STW-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main FSM and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_main_control_if;
    import mc_ctrl_pkg::*;

    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           PCWrite;
    logic           PCWriteCond;
    logic           IorD;
    logic           MemRead;
    logic           MemWrite;
    logic           MemtoReg;
    logic           IRWrite;
    logic [1:0]     PCSource;
    logic [1:0]     ALUop;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic           RegWrite;
    logic           RegDst;
    logic           illegal_op;
    logic [STW-1:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        output MemtoReg, IRWrite, PCSource, ALUop, ALUSrcA,
        output ALUSrcB, RegWrite, RegDst, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        input  MemtoReg, IRWrite, PCSource, ALUop, ALUSrcA,
        input  ALUSrcB, RegWrite, RegDst, illegal_op, state
    );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: state (plus mem_ready in FETCH) to datapath controls.
// ADDI_EN enables decoding of the ADDIEX/ADDIWB states.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Every control defaults to 0; each state raises only what it uses.
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS-subset main control: state register, next-state, illegal_op.
// ADDI_EN adds addi support (DECODE -> ADDIEX -> ADDIWB -> FETCH).
module multicycle_main_control
    import mc_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_main_control_if.master  bus
);

    state_e state_q;
    state_e state_d;
    logic   illegal_q;
    logic   illegal_d;
    ctrl_t  ctrl;

    // Next state; opcode only matters in DECODE and MEMADR.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        unique case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = !is_legal(bus.opcode);
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // State and illegal_op registers; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUop       = ctrl.alu_op;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.illegal_op  = illegal_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control.
// Build with +define+ADDI_EN to exercise the addi path.
module tb_multicycle_main_control;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    multicycle_main_control_if bus ();

    multicycle_main_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock, then check state and the MemRead/MemWrite exclusion.
    task automatic step(input string tag, input logic [3:0] exp_state);
        @(posedge clk);
        #1;
        chk({tag, ".state"}, 32'(bus.state), 32'(exp_state));
        chk({tag, ".rdwr_excl"}, 32'(bus.MemRead & bus.MemWrite), 32'd0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        bus.opcode = 6'b000000;
        bus.mem_ready = 1'b1;

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.state", 32'(bus.state), 32'd0);
        chk("rst.MemRead", 32'(bus.MemRead), 32'd1);
        chk("rst.ALUSrcB", 32'(bus.ALUSrcB), 32'd1);
        chk("rst.ALUop", 32'(bus.ALUop), 32'd0);
        chk("rst.illegal", 32'(bus.illegal_op), 32'd0);
        chk("rst.IRWrite", 32'(bus.IRWrite), 32'd1);
        rst_n = 1'b1;

        // lw
        bus.opcode = 6'b100011;
        step("lw1", 4'd1);
        chk("dec.ALUSrcB", 32'(bus.ALUSrcB), 32'd3);
        step("lw2", 4'd2);
        chk("madr.ALUSrcA", 32'(bus.ALUSrcA), 32'd1);
        chk("madr.ALUSrcB", 32'(bus.ALUSrcB), 32'd2);
        step("lw3", 4'd3);
        chk("mrd.IorD", 32'(bus.IorD), 32'd1);
        chk("mrd.MemRead", 32'(bus.MemRead), 32'd1);
        step("lw4", 4'd4);
        chk("mwb.RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("mwb.MemtoReg", 32'(bus.MemtoReg), 32'd1);
        chk("mwb.RegDst", 32'(bus.RegDst), 32'd0);
        step("lw5", 4'd0);

        // R-type
        bus.opcode = 6'b000000;
        step("r1", 4'd1);
        step("r2", 4'd6);
        chk("exec.ALUop", 32'(bus.ALUop), 32'd2);
        chk("exec.ALUSrcB", 32'(bus.ALUSrcB), 32'd0);
        step("r3", 4'd7);
        chk("alwb.RegDst", 32'(bus.RegDst), 32'd1);
        chk("alwb.RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("alwb.MemtoReg", 32'(bus.MemtoReg), 32'd0);
        step("r4", 4'd0);

        // beq
        bus.opcode = 6'b000100;
        step("beq1", 4'd1);
        step("beq2", 4'd8);
        chk("br.ALUop", 32'(bus.ALUop), 32'd1);
        chk("br.PCWriteCond", 32'(bus.PCWriteCond), 32'd1);
        chk("br.PCSource", 32'(bus.PCSource), 32'd1);
        chk("br.PCWrite", 32'(bus.PCWrite), 32'd0);
        step("beq3", 4'd0);

        // j
        bus.opcode = 6'b000010;
        step("j1", 4'd1);
        step("j2", 4'd9);
        chk("jmp.PCWrite", 32'(bus.PCWrite), 32'd1);
        chk("jmp.PCSource", 32'(bus.PCSource), 32'd2);
        step("j3", 4'd0);

        // sw with three wait cycles
        bus.opcode = 6'b101011;
        step("sw1", 4'd1);
        step("sw2", 4'd2);
        step("sw3", 4'd5);
        bus.mem_ready = 1'b0;
        chk("mwr.MemWrite", 32'(bus.MemWrite), 32'd1);
        chk("mwr.IorD", 32'(bus.IorD), 32'd1);
        step("sw4", 4'd5);
        chk("mwr2.MemWrite", 32'(bus.MemWrite), 32'd1);
        step("sw5", 4'd5);
        step("sw6", 4'd5);
        chk("mwr4.MemWrite", 32'(bus.MemWrite), 32'd1);
        bus.mem_ready = 1'b1;
        step("sw7", 4'd0);
        bus.mem_ready = 1'b0;
        #1;
        chk("fwait.PCWrite", 32'(bus.PCWrite), 32'd0);
        chk("fwait.IRWrite", 32'(bus.IRWrite), 32'd0);
        step("fwait", 4'd0);
        bus.mem_ready = 1'b1;
        #1;
        chk("fgo.PCWrite", 32'(bus.PCWrite), 32'd1);

        // illegal opcode
        bus.opcode = 6'b111111;
        step("ill1", 4'd1);
        chk("ill1.flag", 32'(bus.illegal_op), 32'd0);
        step("ill2", 4'd0);
        chk("ill2.flag", 32'(bus.illegal_op), 32'd1);
        step("ill3", 4'd1);
        chk("ill3.flag", 32'(bus.illegal_op), 32'd0);

        // reset in MEMRD
        bus.opcode = 6'b100011;
        step("ar1", 4'd2);
        step("ar2", 4'd3);
        rst_n = 1'b0;
        step("ar3", 4'd0);
        chk("ar.RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("ar.IorD", 32'(bus.IorD), 32'd0);
        rst_n = 1'b1;

        // addi
        bus.opcode = 6'b001000;
        step("ad1", 4'd1);
`ifdef ADDI_EN
        step("ad2", 4'd10);
        chk("adx.ALUSrcB", 32'(bus.ALUSrcB), 32'd2);
        chk("adx.ALUSrcA", 32'(bus.ALUSrcA), 32'd1);
        step("ad3", 4'd11);
        chk("adw.RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("adw.RegDst", 32'(bus.RegDst), 32'd0);
        step("ad4", 4'd0);
        chk("ad.flag", 32'(bus.illegal_op), 32'd0);
`else
        step("ad2", 4'd0);
        chk("ad.flag", 32'(bus.illegal_op), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
